microseq_ctrl: RTL and testbench

Next-address controller for the microcode engine: decodes the sequencing field of the current microinstruction and drives the command and load address of the microaddress counter. Supports sequential step, jump, opcode dispatch, conditional branch on Z/C, one-level-per-entry call/return stack, and memory wait. It closes the loop between micro-ROM output and the counter: counter `addr` → ROM → this block → counter `cmd`/`load_addr`.

---
 rtl/microseq_ctrl.sv | 129 ++++++++++++
 tb/tb_microseq_ctrl.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/microseq_ctrl.sv
// Next-address controller: decodes the microinstruction sequencing field into counter cmd/load_addr.
// cmd/load_addr are combinational (zero latency); hold stalls all sequencing and stack state.
package microaddr;
    typedef enum logic [1:0] {
        CMD_NONE = 2'd0,
        CMD_INC  = 2'd1,
        CMD_LOAD = 2'd2
    } cmd;
endpackage

module microseq_ctrl #(
    parameter int STACK_DEPTH = 4
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [2:0]                         seq_op,
    input  logic [10:0]                        target,
    input  logic [7:0]                         opcode,
    input  logic                               flag_z,
    input  logic                               flag_c,
    input  logic                               mem_ready,
    input  logic                               hold,
    input  logic [10:0]                        addr,
    output microaddr::cmd                      cmd,
    output logic [10:0]                        load_addr,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   depth,
    output logic                               stack_err
);
    localparam int DW = $clog2(STACK_DEPTH + 1);
    localparam int AW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    localparam logic [2:0] OP_NEXT     = 3'd0;
    localparam logic [2:0] OP_JUMP     = 3'd1;
    localparam logic [2:0] OP_DISPATCH = 3'd2;
    localparam logic [2:0] OP_BRZ      = 3'd3;
    localparam logic [2:0] OP_BRC      = 3'd4;
    localparam logic [2:0] OP_CALL     = 3'd5;
    localparam logic [2:0] OP_RET      = 3'd6;
    localparam logic [2:0] OP_WAIT     = 3'd7;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FAULT = 1'b1
    } state_t;

    state_t        state, state_nxt;
    logic          push, pop, err_set;
    logic [10:0]   stack_mem [2**AW];
    logic [DW-1:0] depth_m1;
    logic          stack_full, stack_empty;

    assign depth_m1    = depth - 1'b1;
    assign stack_full  = (depth >= DW'(STACK_DEPTH));
    assign stack_empty = (depth == '0);

    always_comb begin
        cmd       = microaddr::CMD_NONE;
        load_addr = '0;
        push      = 1'b0;
        pop       = 1'b0;
        err_set   = 1'b0;
        state_nxt = state;
        if (!reset && state == ST_RUN && !hold) begin
            case (seq_op)
                OP_NEXT: cmd = microaddr::CMD_INC;
                OP_JUMP: begin
                    cmd       = microaddr::CMD_LOAD;
                    load_addr = target;
                end
                OP_DISPATCH: begin
                    cmd       = microaddr::CMD_LOAD;
                    load_addr = {opcode, 3'b000};
                end
                OP_BRZ, OP_BRC: begin
                    if ((seq_op == OP_BRZ) ? flag_z : flag_c) begin
                        cmd       = microaddr::CMD_LOAD;
                        load_addr = target;
                    end else begin
                        cmd = microaddr::CMD_INC;
                    end
                end
                OP_CALL: begin
                    if (stack_full) begin
                        err_set   = 1'b1;
                        state_nxt = ST_FAULT;
                    end else begin
                        cmd       = microaddr::CMD_LOAD;
                        load_addr = target;
                        push      = 1'b1;
                    end
                end
                OP_RET: begin
                    if (stack_empty) begin
                        err_set   = 1'b1;
                        state_nxt = ST_FAULT;
                    end else begin
                        cmd       = microaddr::CMD_LOAD;
                        load_addr = stack_mem[depth_m1[AW-1:0]];
                        pop       = 1'b1;
                    end
                end
                OP_WAIT: cmd = mem_ready ? microaddr::CMD_INC : microaddr::CMD_NONE;
                default: cmd = microaddr::CMD_NONE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_RUN;
            depth     <= '0;
            stack_err <= 1'b0;
        end else begin
            state <= state_nxt;
            if (push)
                depth <= depth + 1'b1;
            else if (pop)
                depth <= depth_m1;
            if (err_set)
                stack_err <= 1'b1;
        end
    end

    // Return address is the microword after the CALL; 11-bit wrap is intended.
    always_ff @(posedge clk) begin
        if (push)
            stack_mem[depth[AW-1:0]] <= addr + 11'd1;
    end
endmodule

// File: tb/tb_microseq_ctrl.sv
// Table-driven bench for microseq_ctrl; expectations queued per driven vector and checked before the edge.
module tb_microseq_ctrl;
    localparam int SD = 4;
    localparam int DW = $clog2(SD + 1);

    logic          clk = 1'b0;
    logic          reset;
    logic [2:0]    seq_op;
    logic [10:0]   target;
    logic [7:0]    opcode;
    logic          flag_z, flag_c, mem_ready, hold;
    logic [10:0]   addr;
    microaddr::cmd cmd_w;
    logic [10:0]   load_addr;
    logic [DW-1:0] depth;
    logic          stack_err;

    microseq_ctrl #(.STACK_DEPTH(SD)) dut (
        .clk(clk), .reset(reset), .seq_op(seq_op), .target(target), .opcode(opcode),
        .flag_z(flag_z), .flag_c(flag_c), .mem_ready(mem_ready), .hold(hold), .addr(addr),
        .cmd(cmd_w), .load_addr(load_addr), .depth(depth), .stack_err(stack_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          rst;
        logic [2:0]    op;
        logic [10:0]   tgt;
        logic [7:0]    opc;
        logic          fz, fc, mr, hld;
        logic [10:0]   adr;
        microaddr::cmd e_cmd;
        logic [10:0]   e_load;
        logic [DW-1:0] e_depth;
        logic          e_err;
    } vec_t;

    typedef struct {
        microaddr::cmd e_cmd;
        logic [10:0]   e_load;
        logic [DW-1:0] e_depth;
        logic          e_err;
        int            idx;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;

    localparam microaddr::cmd N = microaddr::CMD_NONE;
    localparam microaddr::cmd I = microaddr::CMD_INC;
    localparam microaddr::cmd L = microaddr::CMD_LOAD;

    function automatic vec_t mk(logic rst, logic [2:0] op, logic [10:0] tgt, logic [7:0] opc,
                                logic fz, logic fc, logic mr, logic hld, logic [10:0] adr,
                                microaddr::cmd ec, logic [10:0] el, logic [DW-1:0] ed, logic ee);
        vec_t v;
        v.rst = rst; v.op = op; v.tgt = tgt; v.opc = opc;
        v.fz = fz; v.fc = fc; v.mr = mr; v.hld = hld; v.adr = adr;
        v.e_cmd = ec; v.e_load = el; v.e_depth = ed; v.e_err = ee;
        return v;
    endfunction

    task automatic apply(input vec_t v, input int idx);
        exp_t e;
        @(negedge clk);
        reset = v.rst; seq_op = v.op; target = v.tgt; opcode = v.opc;
        flag_z = v.fz; flag_c = v.fc; mem_ready = v.mr; hold = v.hld; addr = v.adr;
        e.e_cmd = v.e_cmd; e.e_load = v.e_load; e.e_depth = v.e_depth; e.e_err = v.e_err; e.idx = idx;
        sb.push_back(e);
        #2;
        e = sb.pop_front();
        n_vec++;
        if (cmd_w !== e.e_cmd || load_addr !== e.e_load || depth !== e.e_depth || stack_err !== e.e_err) begin
            n_bad++;
            $display("FAIL vec%0d: got cmd=%0d load=%03h depth=%0d err=%0b, expected cmd=%0d load=%03h depth=%0d err=%0b",
                     e.idx, cmd_w, load_addr, depth, stack_err, e.e_cmd, e.e_load, e.e_depth, e.e_err);
        end
    endtask

    initial begin
        reset = 1'b1; seq_op = 3'd0; target = '0; opcode = '0;
        flag_z = 1'b0; flag_c = 1'b0; mem_ready = 1'b0; hold = 1'b0; addr = '0;
        repeat (2) @(posedge clk);

        //             rst op  tgt     opc    z  c  mr h  addr    cmd load    d  e
        vecs.push_back(mk(1, 0, 11'h000, 8'h00, 0, 0, 0, 0, 11'h000, N, 11'h000, 0, 0));
        vecs.push_back(mk(1, 0, 11'h000, 8'h00, 0, 0, 0, 0, 11'h000, N, 11'h000, 0, 0));
        vecs.push_back(mk(0, 0, 11'h000, 8'h00, 0, 0, 0, 0, 11'h000, I, 11'h000, 0, 0));
        vecs.push_back(mk(0, 2, 11'h000, 8'h2A, 0, 0, 0, 0, 11'h001, L, 11'h150, 0, 0));
        vecs.push_back(mk(0, 3, 11'h040, 8'h00, 0, 1, 0, 0, 11'h150, I, 11'h000, 0, 0));
        vecs.push_back(mk(0, 3, 11'h040, 8'h00, 1, 0, 0, 0, 11'h151, L, 11'h040, 0, 0));
        vecs.push_back(mk(0, 4, 11'h123, 8'h00, 1, 0, 0, 0, 11'h040, I, 11'h000, 0, 0));
        vecs.push_back(mk(0, 4, 11'h123, 8'h00, 0, 1, 0, 0, 11'h041, L, 11'h123, 0, 0));
        vecs.push_back(mk(0, 1, 11'h3FF, 8'h00, 0, 0, 0, 0, 11'h123, L, 11'h3FF, 0, 0));
        // nested call / return
        vecs.push_back(mk(0, 5, 11'h100, 8'h00, 0, 0, 0, 0, 11'h010, L, 11'h100, 0, 0));
        vecs.push_back(mk(0, 5, 11'h200, 8'h00, 0, 0, 0, 0, 11'h101, L, 11'h200, 1, 0));
        vecs.push_back(mk(0, 6, 11'h000, 8'h00, 0, 0, 0, 0, 11'h200, L, 11'h102, 2, 0));
        vecs.push_back(mk(0, 6, 11'h000, 8'h00, 0, 0, 0, 0, 11'h102, L, 11'h011, 1, 0));
        vecs.push_back(mk(0, 0, 11'h000, 8'h00, 0, 0, 0, 0, 11'h011, I, 11'h000, 0, 0));
        // hold freezes a CALL
        vecs.push_back(mk(0, 5, 11'h300, 8'h00, 0, 0, 0, 1, 11'h005, N, 11'h000, 0, 0));
        vecs.push_back(mk(0, 0, 11'h000, 8'h00, 0, 0, 0, 1, 11'h005, N, 11'h000, 0, 0));
        // WAIT: three cycles not ready, one held, then ready
        vecs.push_back(mk(0, 7, 11'h000, 8'h00, 0, 0, 0, 0, 11'h006, N, 11'h000, 0, 0));
        vecs.push_back(mk(0, 7, 11'h000, 8'h00, 0, 0, 0, 0, 11'h006, N, 11'h000, 0, 0));
        vecs.push_back(mk(0, 7, 11'h000, 8'h00, 0, 0, 0, 0, 11'h006, N, 11'h000, 0, 0));
        vecs.push_back(mk(0, 7, 11'h000, 8'h00, 0, 0, 1, 1, 11'h006, N, 11'h000, 0, 0));
        vecs.push_back(mk(0, 7, 11'h000, 8'h00, 0, 0, 1, 0, 11'h006, I, 11'h000, 0, 0));
        // return address wraps at 0x7FF
        vecs.push_back(mk(0, 5, 11'h050, 8'h00, 0, 0, 0, 0, 11'h7FF, L, 11'h050, 0, 0));
        vecs.push_back(mk(0, 6, 11'h000, 8'h00, 0, 0, 0, 0, 11'h050, L, 11'h000, 1, 0));
        vecs.push_back(mk(0, 0, 11'h000, 8'h00, 0, 0, 0, 0, 11'h000, I, 11'h000, 0, 0));
        // underflow, sticky fault, reset recovery
        vecs.push_back(mk(0, 6, 11'h000, 8'h00, 0, 0, 0, 0, 11'h001, N, 11'h000, 0, 0));
        vecs.push_back(mk(0, 0, 11'h000, 8'h00, 0, 0, 0, 0, 11'h001, N, 11'h000, 0, 1));
        vecs.push_back(mk(0, 1, 11'h222, 8'h00, 0, 0, 0, 0, 11'h001, N, 11'h000, 0, 1));
        vecs.push_back(mk(1, 0, 11'h000, 8'h00, 0, 0, 0, 0, 11'h001, N, 11'h000, 0, 1));
        vecs.push_back(mk(0, 0, 11'h000, 8'h00, 0, 0, 0, 0, 11'h000, I, 11'h000, 0, 0));
        // overflow on fifth CALL
        vecs.push_back(mk(0, 5, 11'h010, 8'h00, 0, 0, 0, 0, 11'h001, L, 11'h010, 0, 0));
        vecs.push_back(mk(0, 5, 11'h020, 8'h00, 0, 0, 0, 0, 11'h010, L, 11'h020, 1, 0));
        vecs.push_back(mk(0, 5, 11'h030, 8'h00, 0, 0, 0, 0, 11'h020, L, 11'h030, 2, 0));
        vecs.push_back(mk(0, 5, 11'h040, 8'h00, 0, 0, 0, 0, 11'h030, L, 11'h040, 3, 0));
        vecs.push_back(mk(0, 5, 11'h050, 8'h00, 0, 0, 0, 0, 11'h040, N, 11'h000, 4, 0));
        vecs.push_back(mk(0, 0, 11'h000, 8'h00, 0, 0, 0, 0, 11'h040, N, 11'h000, 4, 1));
        vecs.push_back(mk(0, 6, 11'h000, 8'h00, 0, 0, 0, 0, 11'h040, N, 11'h000, 4, 1));
        vecs.push_back(mk(1, 0, 11'h000, 8'h00, 0, 0, 0, 0, 11'h040, N, 11'h000, 4, 1));
        vecs.push_back(mk(0, 0, 11'h000, 8'h00, 0, 0, 0, 0, 11'h000, I, 11'h000, 0, 0));

        foreach (vecs[i]) apply(vecs[i], i);

        // Hand sequence: RET held for two cycles keeps the stack, then returns the entry pushed last.
        apply(mk(0, 5, 11'h400, 8'h00, 0, 0, 0, 0, 11'h0A0, L, 11'h400, 0, 0), 100);
        apply(mk(0, 6, 11'h000, 8'h00, 0, 0, 0, 1, 11'h400, N, 11'h000, 1, 0), 101);
        apply(mk(0, 6, 11'h000, 8'h00, 0, 0, 0, 1, 11'h400, N, 11'h000, 1, 0), 102);
        apply(mk(0, 6, 11'h000, 8'h00, 0, 0, 0, 0, 11'h400, L, 11'h0A1, 1, 0), 103);
        apply(mk(0, 0, 11'h000, 8'h00, 0, 0, 0, 0, 11'h0A1, I, 11'h000, 0, 0), 104);

        // Hand sequence: reset with nonzero depth empties the stack, so a following RET underflows.
        apply(mk(0, 5, 11'h123, 8'h00, 0, 0, 0, 0, 11'h0B0, L, 11'h123, 0, 0), 110);
        apply(mk(1, 6, 11'h000, 8'h00, 0, 0, 0, 0, 11'h123, N, 11'h000, 1, 0), 111);
        apply(mk(0, 6, 11'h000, 8'h00, 0, 0, 0, 0, 11'h000, N, 11'h000, 0, 0), 112);
        apply(mk(0, 0, 11'h000, 8'h00, 0, 0, 0, 0, 11'h000, N, 11'h000, 0, 1), 113);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
